// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared types and constants for the UART transmit arbiter.
//   arb_state_e : arbiter FSM state codes (IDLE=0, START=1, WAIT_BUSY=2,
//                 WAIT_DONE=3).
//   IDX_W       : width of a requester index (owner / pointer), up to 8
//                 requesters.
//   last_idx()  : index of the last requester, the pointer value after reset
//                 so requester 0 is searched first.
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_START     = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int IDX_W = 3;

    function automatic logic [IDX_W-1:0] last_idx(input int num_req);
        return IDX_W'(num_req - 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester side and the uart_transmit side of the arbiter.
//   req       : per-requester request level, held until req_ack
//   req_data  : flattened bytes, requester i at [i*DATA_W +: DATA_W]
//   req_ack   : one-cycle pulse, byte latched
//   req_done  : one-cycle pulse, byte fully shifted out
//   tx_send   : one-cycle send pulse to uart_transmit
//   tx_data   : byte to uart_transmit, stable from grant to idle
//   tx_ready  : ready from uart_transmit
//   busy      : arbiter not idle
//   owner     : current / last granted requester
//   err       : one-cycle watchdog abort pulse
//   state     : FSM state, debug visibility
// Handshake: a requester raises req and holds req/req_data until it sees
// its req_ack bit; after that it may drop req or change its byte. The
// uart side sees one tx_send pulse per byte, then ready falls while the
// frame shifts and rises again when the frame is finished.
// Modports: slave = arbiter, master = requesters plus uart model.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8
);
    import uart_tx_arbiter_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        req_done;
    logic                      tx_send;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;
    logic                      busy;
    logic [IDX_W-1:0]          owner;
    logic                      err;
    arb_state_e                state;

    modport slave (
        input  req, req_data, tx_ready,
        output req_ack, req_done, tx_send, tx_data, busy, owner, err, state
    );

    modport master (
        output req, req_data, tx_ready,
        input  req_ack, req_done, tx_send, tx_data, busy, owner, err, state
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_rr_pick
// Combinational round-robin picker.
//   req_i    : request vector
//   ptr_i    : index of the last winner
//   any_o    : at least one request present
//   winner_o : first set bit searching upward from ptr_i+1, wrapping
// ---------------------------------------------------------------------------
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [IDX_W-1:0]   winner_o
);
    logic             hi_hit;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Walking downward leaves the lowest matching index in each variable:
    // hi_idx is the lowest request above the pointer, lo_idx the lowest
    // request overall (used when the search wraps past the top).
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                lo_idx = IDX_W'(j);
                if (IDX_W'(j) > ptr_i) begin
                    hi_hit = 1'b1;
                    hi_idx = IDX_W'(j);
                end
            end
        end
        any_o    = |req_i;
        winner_o = hi_hit ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_transmit between NUM_REQ byte sources with round-robin
// arbitration. Latches the winning byte, issues one send pulse, follows
// uart_transmit's ready to detect completion, and reports per-requester
// accept (req_ack) and completion (req_done). All outputs are registered.
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_tx_arbiter_if.slave (requests, uart handshake, status)
// Optional build macro UART_ARB_TIMEOUT_EN adds a TO_W-bit watchdog on the
// wait states; on expiry err pulses and the FSM returns to idle without
// req_done. Without the macro err is tied to 0 and the FSM waits forever.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8,
    parameter int TO_W    = 20
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    arb_state_e         state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] done_q;
    logic               send_q;
    logic               busy_q;
    logic [DATA_W-1:0]  data_q;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  pick_byte;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] owner_oh;
    logic               to_hit;

`ifdef UART_ARB_TIMEOUT_EN
    // Abort on the edge where the counter reaches all-ones, i.e. after
    // 2^TO_W-1 cycles spent in the wait states.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;
    assign to_hit  = (to_cnt_q == TO_LAST);
    assign bus.err = err_q;
`else
    logic [TO_W-1:0] unused_to_w;
    assign unused_to_w = '0;
    assign to_hit      = 1'b0;
    assign bus.err     = 1'b0;
`endif

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .winner_o (pick_idx)
    );

    // Winner byte select and index-to-one-hot for ack/done pulses.
    always_comb begin
        pick_byte = '0;
        pick_oh   = '0;
        owner_oh  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick_idx == IDX_W'(j)) begin
                pick_byte  = bus.req_data[j*DATA_W +: DATA_W];
                pick_oh[j] = 1'b1;
            end
            if (owner_q == IDX_W'(j)) begin
                owner_oh[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= last_idx(NUM_REQ);
            owner_q <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            ack_q  <= '0;
            done_q <= '0;
            send_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                ARB_IDLE: begin
                    // No grant while uart_transmit is not ready (e.g. it
                    // is still held in reset).
                    if (pick_any && bus.tx_ready) begin
                        data_q  <= pick_byte;
                        owner_q <= pick_idx;
                        ptr_q   <= pick_idx;
                        ack_q   <= pick_oh;
                        busy_q  <= 1'b1;
                        state_q <= ARB_START;
                    end
                end
                ARB_START: begin
                    send_q  <= 1'b1;
                    state_q <= ARB_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                end
                ARB_WAIT_BUSY: begin
                    // Ready falling means uart_transmit took the byte.
                    if (!bus.tx_ready) begin
                        state_q <= ARB_WAIT_DONE;
                    end else if (to_hit) begin
                        busy_q  <= 1'b0;
                        state_q <= ARB_IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                        err_q   <= 1'b1;
`endif
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt_q <= to_cnt_q + 1'b1;
`endif
                end
                ARB_WAIT_DONE: begin
                    // A completed frame takes precedence over a watchdog
                    // expiring on the same edge. The pointer already holds
                    // the owner, so an aborted owner is not favoured.
                    if (bus.tx_ready) begin
                        done_q  <= owner_oh;
                        busy_q  <= 1'b0;
                        state_q <= ARB_IDLE;
                    end else if (to_hit) begin
                        busy_q  <= 1'b0;
                        state_q <= ARB_IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                        err_q   <= 1'b1;
`endif
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt_q <= to_cnt_q + 1'b1;
`endif
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ack  = ack_q;
    assign bus.req_done = done_q;
    assign bus.tx_send  = send_q;
    assign bus.tx_data  = data_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
    assign bus.state    = state_q;

endmodule
